// File: rtl/sram1_host_arb.sv
// Arbiter sharing the single-port data SRAM between the core LSU (always wins)
// and a host burst port that uses idle core cycles for load/dump traffic.
//
// state | meaning
// IDLE  | waiting for a host command, cmd_rdy=1
// WR    | host write burst, one word per idle core cycle
// RD    | host read burst, issuing reads while FIFO credit remains
// DRAIN | all reads issued, waiting for in-flight data and FIFO to empty
module sram1_host_arb #(
  parameter int AW         = 14,
  parameter int LENW       = 8,
  parameter int STARVE_MAX = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [15:0]     dat_a,
  input  logic [3:0]      dat_we,
  input  logic [31:0]     dat_wd,
  input  logic [3:0]      dat_re,
  output logic [31:0]     dat_rd,
  output logic [AW-1:0]   sram_a,
  output logic [3:0]      sram_we,
  output logic [31:0]     sram_wd,
  output logic [3:0]      sram_re,
  input  logic [31:0]     sram_rd,
  input  logic            cmd_vld,
  output logic            cmd_rdy,
  input  logic            cmd_wr,
  input  logic [AW-1:0]   cmd_a,
  input  logic [LENW-1:0] cmd_len,
  input  logic            wd_vld,
  output logic            wd_rdy,
  input  logic [31:0]     wd,
  output logic            rd_vld,
  input  logic            rd_rdy,
  output logic [31:0]     rd,
  output logic            busy,
  output logic            starve
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WR    = 2'd1;
  localparam logic [1:0] S_RD    = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]   SMAX    = SW'(STARVE_MAX);
  localparam logic [SW-1:0]   S_ONE   = SW'(1);
  localparam logic [AW-1:0]   A_ONE   = AW'(1);
  localparam logic [LENW-1:0] L_ONE   = LENW'(1);

  logic [1:0]      state;
  logic [AW-1:0]   cur_a;
  logic [LENW-1:0] rem;
  logic            inflight;
  logic [1:0]      fifo_cnt;
  logic            fifo_wptr;
  logic            fifo_rptr;
  logic [31:0]     fifo_mem [2];
  logic [SW-1:0]   starve_cnt;

  logic core_act;
  logic credit;
  logic wr_go;
  logic rd_go;
  logic host_grant;
  logic host_blocked;
  logic fifo_push;
  logic fifo_pop;
  logic unused_bits;

  assign unused_bits = ^dat_a[1:0];

  assign core_act = (|dat_we) | (|dat_re);
  // Pop does not return credit in the same cycle; keeps the FIFO at two entries.
  assign credit   = (({1'b0, fifo_cnt}) + {2'b00, inflight}) < 3'd2;
  assign wr_go    = (state == S_WR) && wd_vld && !core_act;
  assign rd_go    = (state == S_RD) && credit && !core_act;

  assign host_grant   = wr_go | rd_go;
  assign host_blocked = core_act &&
                        (((state == S_WR) && wd_vld) || ((state == S_RD) && credit));

  assign fifo_push = inflight;
  assign fifo_pop  = rd_vld && rd_rdy;

  assign dat_rd  = sram_rd;
  assign cmd_rdy = (state == S_IDLE);
  assign wd_rdy  = (state == S_WR) && !core_act;
  assign rd_vld  = (fifo_cnt != 2'd0);
  assign rd      = fifo_mem[fifo_rptr];
  assign busy    = (state != S_IDLE);
  assign starve  = (starve_cnt == SMAX);

  always_comb begin
    sram_a  = dat_a[AW+1:2];
    sram_we = dat_we;
    sram_wd = dat_wd;
    sram_re = dat_re;
    if (!core_act) begin
      sram_we = 4'h0;
      sram_re = 4'h0;
      if (wr_go) begin
        sram_a  = cur_a;
        sram_we = 4'hF;
        sram_wd = wd;
      end else if (rd_go) begin
        sram_a  = cur_a;
        sram_re = 4'hF;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      cur_a <= '0;
      rem   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_vld) begin
            cur_a <= cmd_a;
            rem   <= cmd_len;
            state <= cmd_wr ? S_WR : S_RD;
          end
        end
        S_WR: begin
          if (wr_go) begin
            cur_a <= cur_a + A_ONE;
            rem   <= rem - L_ONE;
            if (rem == '0) state <= S_IDLE;
          end
        end
        S_RD: begin
          if (rd_go) begin
            cur_a <= cur_a + A_ONE;
            rem   <= rem - L_ONE;
            if (rem == '0) state <= S_DRAIN;
          end
        end
        default: begin
          if (!inflight && (fifo_cnt == 2'd0)) state <= S_IDLE;
        end
      endcase
    end
  end

  // Read result arrives one cycle after issue; inflight marks that capture slot.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight    <= 1'b0;
      fifo_cnt    <= 2'd0;
      fifo_wptr   <= 1'b0;
      fifo_rptr   <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      inflight <= rd_go;
      if (fifo_push) begin
        fifo_mem[fifo_wptr] <= sram_rd;
        fifo_wptr           <= ~fifo_wptr;
      end
      if (fifo_pop) fifo_rptr <= ~fifo_rptr;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt <= '0;
    end else if ((state == S_IDLE) || host_grant) begin
      starve_cnt <= '0;
    end else if (host_blocked && (starve_cnt != SMAX)) begin
      starve_cnt <= starve_cnt + S_ONE;
    end
  end

endmodule

// File: tb/tb_sram1_host_arb.sv
// Scoreboard bench for sram1_host_arb: expected SRAM writes and host read words
// are queued by the stimulus and popped by negedge monitors.
module tb_sram1_host_arb;

  logic        clk;
  logic        rstn;
  logic [15:0] dat_a;
  logic [3:0]  dat_we;
  logic [31:0] dat_wd;
  logic [3:0]  dat_re;
  logic [31:0] dat_rd;
  logic [13:0] sram_a;
  logic [3:0]  sram_we;
  logic [31:0] sram_wd;
  logic [3:0]  sram_re;
  logic [31:0] sram_rd;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic        cmd_wr;
  logic [13:0] cmd_a;
  logic [7:0]  cmd_len;
  logic        wd_vld;
  logic        wd_rdy;
  logic [31:0] wd;
  logic        rd_vld;
  logic        rd_rdy;
  logic [31:0] rd;
  logic        busy;
  logic        starve;

  sram1_host_arb #(.AW(14), .LENW(8), .STARVE_MAX(64)) dut (
    .clk(clk), .rstn(rstn),
    .dat_a(dat_a), .dat_we(dat_we), .dat_wd(dat_wd), .dat_re(dat_re), .dat_rd(dat_rd),
    .sram_a(sram_a), .sram_we(sram_we), .sram_wd(sram_wd), .sram_re(sram_re), .sram_rd(sram_rd),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_wr(cmd_wr), .cmd_a(cmd_a), .cmd_len(cmd_len),
    .wd_vld(wd_vld), .wd_rdy(wd_rdy), .wd(wd),
    .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd(rd),
    .busy(busy), .starve(starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: byte writes, read data registered one cycle after the request
  logic [31:0] mem [0:16383];
  logic [31:0] rd_q;
  assign sram_rd = rd_q;
  initial rd_q = '0;
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (sram_we[b]) mem[sram_a][b*8 +: 8] <= sram_wd[b*8 +: 8];
    if (|sram_re) rd_q <= mem[sram_a];
  end

  typedef struct packed {
    logic [13:0] a;
    logic [3:0]  we;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  int          n_chk;
  int          n_fail;
  wr_t         mon_e;
  logic [31:0] mon_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input logic [13:0] a, input logic [31:0] d);
    wr_t e;
    e.a  = a;
    e.we = 4'hF;
    e.d  = d;
    exp_wr.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    chk("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic issue_cmd(input logic wr, input logic [13:0] a, input logic [7:0] len);
    cmd_vld = 1'b1;
    cmd_wr  = wr;
    cmd_a   = a;
    cmd_len = len;
    tick();
    cmd_vld = 1'b0;
  endtask

  always @(negedge clk) begin
    if (sram_we != 4'h0) begin
      if (exp_wr.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wr_unexpected: got a=%h d=%h expected no write", sram_a, sram_wd);
      end else begin
        mon_e = exp_wr.pop_front();
        chk("wr_addr", {18'b0, sram_a}, {18'b0, mon_e.a});
        chk("wr_we", {28'b0, sram_we}, {28'b0, mon_e.we});
        chk("wr_data", sram_wd, mon_e.d);
      end
    end
    if (rd_vld && rd_rdy) begin
      if (exp_rd.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rd_unexpected: got %h expected no read word", rd);
      end else begin
        mon_d = exp_rd.pop_front();
        chk("rd_data", rd, mon_d);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  int nrd;

  initial begin
    n_chk = 0; n_fail = 0;
    rstn = 1'b0;
    dat_a = '0; dat_we = '0; dat_wd = '0; dat_re = '0;
    cmd_vld = 1'b0; cmd_wr = 1'b0; cmd_a = '0; cmd_len = '0;
    wd_vld = 1'b0; wd = '0; rd_rdy = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_rd_vld", {31'b0, rd_vld}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_starve", {31'b0, starve}, 32'd0);
    chk("rst_cmd_rdy", {31'b0, cmd_rdy}, 32'd1);
    chk("rst_wd_rdy", {31'b0, wd_rdy}, 32'd0);
    tick();
    rstn = 1'b1;
    tick();

    // write burst 0x10..0x13, core idle
    chk("cmd_rdy_idle", {31'b0, cmd_rdy}, 32'd1);
    issue_cmd(1'b1, 14'h0010, 8'd3);
    wd_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wd = 32'hA0 + 32'(i);
      push_wr(14'h0010 + 14'(i), 32'hA0 + 32'(i));
      @(negedge clk);
      chk("wr_wd_rdy", {31'b0, wd_rdy}, 32'd1);
      chk("wr_busy", {31'b0, busy}, 32'd1);
      tick();
    end
    wd_vld = 1'b0;
    @(negedge clk);
    chk("wr_busy_fall", {31'b0, busy}, 32'd0);
    chk("mem_10", mem[16'h10], 32'hA0);
    chk("mem_13", mem[16'h13], 32'hA3);
    tick();

    // read burst with backpressure
    rd_rdy = 1'b0;
    for (int i = 0; i < 4; i++) exp_rd.push_back(32'hA0 + 32'(i));
    issue_cmd(1'b0, 14'h0010, 8'd3);
    nrd = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (sram_re != 4'h0) nrd++;
      if (c >= 2) chk("rd_vld_hold", {31'b0, rd_vld}, 32'd1);
      tick();
    end
    chk("reads_issued", 32'(nrd), 32'd2);
    rd_rdy = 1'b1;
    wait_idle(60);
    chk("rd_q_empty", 32'(exp_rd.size()), 32'd0);
    tick();

    // core write collides with pending host write
    issue_cmd(1'b1, 14'h0020, 8'd0);
    wd_vld = 1'b1; wd = 32'h5555AAAA;
    dat_we = 4'hF; dat_a = 16'h0040; dat_wd = 32'hC0DE0040;
    push_wr(14'h0010, 32'hC0DE0040);
    @(negedge clk);
    chk("contend_wd_rdy", {31'b0, wd_rdy}, 32'd0);
    tick();
    dat_we = 4'h0;
    push_wr(14'h0020, 32'h5555AAAA);
    @(negedge clk);
    chk("contend_wd_rdy_free", {31'b0, wd_rdy}, 32'd1);
    tick();
    wd_vld = 1'b0;
    dat_re = 4'hF; dat_a = 16'h0040;
    chk("contend_busy", {31'b0, busy}, 32'd0);
    tick();
    dat_re = 4'h0;
    @(negedge clk);
    chk("core_load", dat_rd, 32'hC0DE0040);
    tick();

    // starvation under back-to-back core loads
    issue_cmd(1'b1, 14'h0030, 8'd0);
    wd_vld = 1'b1; wd = 32'h5A5A0030;
    dat_re = 4'hF; dat_a = 16'h0080;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (i == 63) chk("starve_63", {31'b0, starve}, 32'd0);
      if (i == 64) chk("starve_64", {31'b0, starve}, 32'd1);
      if (i == 70) chk("starve_70", {31'b0, starve}, 32'd1);
    end
    dat_re = 4'h0;
    push_wr(14'h0030, 32'h5A5A0030);
    @(negedge clk);
    chk("starve_grant_rdy", {31'b0, wd_rdy}, 32'd1);
    tick();
    wd_vld = 1'b0;
    @(negedge clk);
    chk("starve_clear", {31'b0, starve}, 32'd0);
    tick();

    // address wrap
    issue_cmd(1'b1, 14'h3FFE, 8'd3);
    wd_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wd = 32'h11 + 32'(i);
      push_wr(14'h3FFE + 14'(i), 32'h11 + 32'(i));
      tick();
    end
    wd_vld = 1'b0;
    @(negedge clk);
    chk("wrap_busy", {31'b0, busy}, 32'd0);
    chk("mem_0000", mem[16'h0000], 32'h13);
    chk("mem_0001", mem[16'h0001], 32'h14);
    tick();

    // reset with one word buffered and one in flight
    rd_rdy = 1'b0;
    for (int i = 0; i < 4; i++) exp_rd.push_back(32'hA0 + 32'(i));
    issue_cmd(1'b0, 14'h0010, 8'd3);
    tick();
    tick();
    chk("pre_rst_rd_vld", {31'b0, rd_vld}, 32'd1);
    rstn = 1'b0;
    #1;
    exp_rd.delete();
    chk("midrst_rd_vld", {31'b0, rd_vld}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_cmd_rdy", {31'b0, cmd_rdy}, 32'd1);
    tick();
    rstn = 1'b1;
    rd_rdy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("post_rst_rd_vld", {31'b0, rd_vld}, 32'd0);
      tick();
    end

    chk("wr_q_empty", 32'(exp_wr.size()), 32'd0);
    chk("rd_q_final", 32'(exp_rd.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
